// File: rtl/decoder_seq_pkg.sv
// Shared types for decoder_seq_nx2n.
//   state_e   : controller states (IDLE, HOLD)
//   MODE_*    : encoding of the request mode bit
//   onehot()  : reference one-hot helper, up to 64 lines
package decoder_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic logic [63:0] onehot(input logic [5:0] idx, input logic en);
    return en ? (64'd1 << idx) : 64'd0;
  endfunction

endpackage

// File: rtl/decoder_seq_nx2n_if.sv
// Request/strobe bundle for decoder_seq_nx2n.
//   master : requester side (drives in_valid/in_mode/in_addr/in_hold)
//   slave  : decoder side (drives in_ready and the out_* strobe signals)
interface decoder_seq_nx2n_if #(
  parameter int IN_W   = 4,
  parameter int HOLD_W = 4
) ();
  localparam int OUT_W = 2 ** IN_W;

  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [IN_W-1:0]   in_addr;
  logic [HOLD_W-1:0] in_hold;
  logic [OUT_W-1:0]  out_y;
  logic [IN_W-1:0]   out_idx;
  logic              out_valid;
  logic              scan_done;

  modport master (
    output in_valid, in_mode, in_addr, in_hold,
    input  in_ready, out_y, out_idx, out_valid, scan_done
  );

  modport slave (
    input  in_valid, in_mode, in_addr, in_hold,
    output in_ready, out_y, out_idx, out_valid, scan_done
  );
endinterface

// File: rtl/decoder_seq_nx2n_core.sv
// dec_onehot_core: combinational enable-gated IN_W -> 2^IN_W decoder.
//   en   : all outputs forced low when 0
//   addr : selected line
//   y    : one-hot (or zero) result
module dec_onehot_core #(
  parameter int IN_W  = 4,
  localparam int OUT_W = 2 ** IN_W
) (
  input  logic             en,
  input  logic [IN_W-1:0]  addr,
  output logic [OUT_W-1:0] y
);
  // One comparator per line; a single en gate replaces the old
  // cascaded enables of the 3x8 stages.
  for (genvar i = 0; i < OUT_W; i++) begin : g_line
    assign y[i] = en && (addr == IN_W'(i));
  end
endmodule

// File: rtl/decoder_seq_nx2n.sv
// decoder_seq_nx2n: registered one-hot decoder with programmable hold.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of decoder_seq_nx2n_if
//                direct mode holds one line for hold+1 cycles,
//                scan mode walks the line upward, hold+1 cycles per line.
// Optional: DECODER_SEQ_SCAN_WRAP_EN makes scans wrap around and end
// on the line just below the start index.
module decoder_seq_nx2n
  import decoder_seq_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int HOLD_W = 4,
  localparam int OUT_W = 2 ** IN_W
) (
  input  logic                clk,
  input  logic                rst_n,
  decoder_seq_nx2n_if.slave   bus
);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]   last_q, last_d;
  logic [IN_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]  y_q, y_d;
  logic              done_q, done_d;
  logic              act_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    idx_d   = idx_q;
    act_d   = (state_q == HOLD);
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = HOLD;
          mode_d  = bus.in_mode;
          hold_d  = bus.in_hold;
          cnt_d   = bus.in_hold;
          idx_d   = bus.in_addr;
          act_d   = 1'b1;
`ifdef DECODER_SEQ_SCAN_WRAP_EN
          last_d  = IN_W'(bus.in_addr - 1'b1);
`else
          last_d  = '1;
`endif
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (mode_q == MODE_SCAN && idx_q != last_q) begin
          // Next line; the index increment is naturally mod 2^IN_W.
          idx_d = IN_W'(idx_q + 1'b1);
          cnt_d = hold_q;
        end else begin
          state_d = IDLE;
          idx_d   = '0;
          act_d   = 1'b0;
          done_d  = (mode_q == MODE_SCAN);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // out_y is always rebuilt from the next index, so it can never be multi-hot.
  dec_onehot_core #(.IN_W(IN_W)) u_core (
    .en   (act_d),
    .addr (idx_d),
    .y    (y_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_DIRECT;
      hold_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_y     = y_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = |y_q;
  assign bus.scan_done = done_q;

endmodule

// File: tb/tb_decoder_seq_nx2n.sv
// Self-checking bench for decoder_seq_nx2n (IN_W=4, HOLD_W=4).
// A queue model expands each accepted request into its per-cycle output
// trace; a negedge process compares the DUT with it every cycle, and the
// directed tests add literal expectations.
module tb_decoder_seq_nx2n;

  localparam int IN_W = 4, HOLD_W = 4, OUT_W = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  decoder_seq_nx2n_if #(.IN_W(IN_W), .HOLD_W(HOLD_W)) bus ();
  decoder_seq_nx2n #(.IN_W(IN_W), .HOLD_W(HOLD_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [OUT_W-1:0] y;
    logic [IN_W-1:0]  idx;
    logic             done;
    logic             busy;
  } exp_t;

  exp_t q[$];
  exp_t cur = '{y: '0, idx: '0, done: 1'b0, busy: 1'b0};

  task automatic build(input logic m, input logic [3:0] a, input logic [3:0] h);
    int n;
    exp_t e;
`ifdef DECODER_SEQ_SCAN_WRAP_EN
    n = m ? OUT_W : 1;
`else
    n = m ? OUT_W - int'(a) : 1;
`endif
    for (int l = 0; l < n; l++) begin
      int line;
      line = (int'(a) + l) % OUT_W;
      for (int c = 0; c <= int'(h); c++) begin
        e.y = OUT_W'(1) << line; e.idx = IN_W'(line); e.done = 1'b0; e.busy = 1'b1;
        q.push_back(e);
      end
    end
    if (m) begin
      e.y = '0; e.idx = '0; e.done = 1'b1; e.busy = 1'b0;
      q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      cur = '{y: '0, idx: '0, done: 1'b0, busy: 1'b0};
    end else begin
      if (bus.in_valid && !cur.busy) build(bus.in_mode, bus.in_addr, bus.in_hold);
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{y: '0, idx: '0, done: 1'b0, busy: 1'b0};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_y", 32'(bus.out_y), 32'(cur.y));
      chk("m_out_idx", 32'(bus.out_idx), 32'(cur.idx));
      chk("m_scan_done", 32'(bus.scan_done), 32'(cur.done));
      chk("m_in_ready", 32'(bus.in_ready), 32'(!cur.busy));
      chk("m_out_valid", 32'(bus.out_valid), 32'(|cur.y));
      chk("inv_onehot", 32'($countones(bus.out_y) <= 1), 32'd1);
      chk("inv_valid", 32'(bus.out_valid), 32'(|bus.out_y));
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic m, input logic [3:0] a, input logic [3:0] h);
    int t = 0;
    bus.in_valid = 1'b1; bus.in_mode = m; bus.in_addr = a; bus.in_hold = h;
    while (!bus.in_ready && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) chk("send_timeout", 32'(t), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_addr = '0; bus.in_hold = '0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("rst_y", 32'(bus.out_y), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_done", 32'(bus.scan_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // direct, addr 5, hold 0
    send(1'b0, 4'd5, 4'd0);
    chk("d5_y", 32'(bus.out_y), 32'h0020);
    chk("d5_idx", 32'(bus.out_idx), 32'd5);
    chk("d5_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("d5_y_off", 32'(bus.out_y), 32'h0);
    chk("d5_ready_back", 32'(bus.in_ready), 32'd1);

    // direct, addr 15, hold 3, with a new request held during HOLD
    send(1'b0, 4'd15, 4'd3);
    chk("d15_y0", 32'(bus.out_y), 32'h8000);
    bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_addr = 4'd2; bus.in_hold = 4'd0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("d15_y", 32'(bus.out_y), 32'h8000);
      chk("d15_busy", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    chk("d15_gap_y", 32'(bus.out_y), 32'h0);
    chk("d15_gap_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("d2_y", 32'(bus.out_y), 32'h0004);
    @(negedge clk);
    chk("d2_y_off", 32'(bus.out_y), 32'h0);

    // hold all-ones: 16 cycles on line 0
    send(1'b0, 4'd0, 4'd15);
    begin
      int n = 1;
      while (bus.out_y == 16'h0001 && n < 40) begin @(negedge clk); n++; end
      chk("hold15_len", 32'(n - 1), 32'd16);
    end

`ifndef DECODER_SEQ_SCAN_WRAP_EN
    // scan 13, hold 1
    @(negedge clk);
    send(1'b1, 4'd13, 4'd1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk("s13_y", 32'(bus.out_y), 32'h2000 << (i / 2));
      chk("s13_busy", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    chk("s13_done", 32'(bus.scan_done), 32'd1);
    chk("s13_y_off", 32'(bus.out_y), 32'h0);
    @(negedge clk);
    chk("s13_done_pulse", 32'(bus.scan_done), 32'd0);

    // scan from the top line is one step
    send(1'b1, 4'd15, 4'd0);
    chk("s15_y", 32'(bus.out_y), 32'h8000);
    @(negedge clk);
    chk("s15_done", 32'(bus.scan_done), 32'd1);
    @(negedge clk);
`else
    // wrapping scan from 14, hold 0
    @(negedge clk);
    send(1'b1, 4'd14, 4'd0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk("w14_idx", 32'(bus.out_idx), 32'((14 + i) % 16));
      chk("w14_done_early", 32'(bus.scan_done), 32'd0);
    end
    @(negedge clk);
    chk("w14_done", 32'(bus.scan_done), 32'd1);
    @(negedge clk);
`endif

    // reset in the middle of a hold=7 direct op
    send(1'b0, 4'd9, 4'd7);
    chk("r9_y", 32'(bus.out_y), 32'h0200);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("r9_y_off", 32'(bus.out_y), 32'h0);
    chk("r9_ready", 32'(bus.in_ready), 32'd1);
    chk("r9_no_done", 32'(bus.scan_done), 32'd0);
    send(1'b0, 4'd3, 4'd0);
    chk("r3_y", 32'(bus.out_y), 32'h0008);
    @(negedge clk);
    chk("r3_y_off", 32'(bus.out_y), 32'h0);

    // random accept/stall traffic
    begin
      int ops = 0, cyc = 0;
      bit acc;
      while (ops < 1000 && cyc < 60000) begin
        if (!bus.in_valid && $urandom_range(0, 2) == 0) begin
          bus.in_valid = 1'b1;
          bus.in_mode  = 1'($urandom);
          bus.in_addr  = 4'($urandom);
          bus.in_hold  = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 2));
        end else if (!bus.in_valid) begin
          bus.in_addr = 4'($urandom);
          bus.in_hold = 4'($urandom);
        end
        acc = bus.in_valid && bus.in_ready;
        @(negedge clk);
        cyc++;
        if (acc) begin ops++; bus.in_valid = 1'b0; end
      end
      chk("rand_ops", 32'(ops), 32'd1000);
    end
    repeat (300) @(negedge clk);
    chk("end_idle", 32'(bus.in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
